// File: rtl/tohost_pkg.sv
// Shared types and helpers for the tohost/fromhost test monitor.
// Latency: n/a (package: state encoding, constants, byte-merge helper).
// Backpressure: n/a.
package tohost_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // riscv-tests writes exactly 1 to tohost on success
  localparam logic [31:0] PASS_CODE         = 32'h0000_0001;
  localparam logic [31:0] DEF_TOHOST_ADDR   = 32'h0000_1000;
  localparam logic [31:0] DEF_FROMHOST_ADDR = 32'h0000_1040;

  // Merge the byte lanes selected by we from new_w into old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/tohost_cycle_counter.sv
// Saturating 32-bit cycle counter with enable and a terminal-value match flag.
// Latency: count updates at the edge after en; at_term is combinational on count.
// Backpressure: none; holds at 32'hFFFF_FFFF instead of wrapping.
module tohost_cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] term,
  output logic [31:0] count,
  output logic        at_term
);

  // count enabled cycles, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/tohost_monitor.sv
// Memory-mapped tohost/fromhost responder that turns tohost stores into a sticky verdict.
// Latency: verdict and read data appear one cycle after the bus access; mem_hit is combinational.
// Backpressure: none on the bus; halt_req asks the core to stall once a verdict exists.
// Optional: define TOHOST_WATCHDOG_EN to build the TIMEOUT_CYCLES watchdog.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter logic [31:0] FROMHOST_ADDR  = DEF_FROMHOST_ADDR,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_wdata,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        mem_hit,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [30:0] test_code,
  output logic [31:0] cycle_count,
  output logic        halt_req
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] tohost;
  logic [31:0] fromhost;
  logic [31:0] to_nxt;
  logic        hit_to;
  logic        hit_from;
  logic        wr_any;
  logic        to_wr;
  logic        run_en;
  logic        unused_addr_lsb;

  // word decode: byte-offset bits never take part
  assign hit_to          = (mem_addr[31:2] == TOHOST_ADDR[31:2]);
  assign hit_from        = (mem_addr[31:2] == FROMHOST_ADDR[31:2]);
  assign mem_hit         = hit_to | hit_from;
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign wr_any = |mem_we;
  assign to_nxt = merge_bytes(tohost, mem_wdata, mem_we);
  // tohost freezes as soon as a verdict exists
  assign to_wr  = wr_any & hit_to & (state == RUN);
  assign run_en = (state == RUN);

`ifdef TOHOST_WATCHDOG_EN
  logic at_term;
  logic timeout_hit;

  tohost_cycle_counter u_run_counter (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .en      (run_en),
    .term    (TIMEOUT_CYCLES - 32'd1),
    .count   (cycle_count),
    .at_term (at_term)
  );

  // zero timeout budget means the watchdog never fires
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && at_term;
`else
  logic        unused_at_term;
  logic [31:0] unused_timeout_cfg;

  tohost_cycle_counter u_run_counter (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .en      (run_en),
    .term    (32'hFFFF_FFFF),
    .count   (cycle_count),
    .at_term (unused_at_term)
  );

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

  // verdict state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= RUN;
    else            state <= state_nxt;
  end

  // next verdict from the merged tohost word; a verdict store beats the watchdog
  always_comb begin
    state_nxt    = state;
    test_done    = 1'b0;
    test_pass    = 1'b0;
    test_timeout = 1'b0;
    test_code    = 31'd0;

    if (state == RUN) begin
      if (to_wr && (to_nxt == PASS_CODE)) begin
        state_nxt = PASS;
      end else if (to_wr && to_nxt[0]) begin
        state_nxt = FAIL;
`ifdef TOHOST_WATCHDOG_EN
      end else if (timeout_hit) begin
        state_nxt = TIMEOUT;
`endif
      end
    end

    case (state)
      PASS:    begin test_done = 1'b1; test_pass = 1'b1; end
      FAIL:    begin test_done = 1'b1; test_code = tohost[31:1]; end
      TIMEOUT: begin test_done = 1'b1; test_timeout = 1'b1; end
      default: ;
    endcase
  end

  assign halt_req = test_done;

  // register writes and one-cycle read data; reads see pre-write contents
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tohost    <= 32'd0;
      fromhost  <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if (to_wr) tohost <= to_nxt;
      if (wr_any && hit_from) fromhost <= merge_bytes(fromhost, mem_wdata, mem_we);
      if (mem_re && mem_hit) mem_rdata <= hit_to ? tohost : fromhost;
      else                   mem_rdata <= 32'd0;
    end
  end

endmodule
